uart_tx_periph: RTL
===================

# uart_tx_periph

Memory-mapped UART transmitter occupying the peripheral branch of the bus interface unit, at byte addresses 0x1000 and above. The CPU stores bytes into an 8-entry transmit FIFO. A baud-divider state machine serialises each byte onto `txd` as 8N1 frames. Status and divisor registers are readable, so software can poll FIFO state.

## Interface
- `BASE_ADDR`, 32'h0000_1000: byte address of register 0. Registers are decoded on `daddr[3:2]` relative to `BASE_ADDR`.
- `FIFO_DEPTH`, 8: number of transmit FIFO entries. Must be a power of two, from 2 to 16.
- `DIV_RESET`, 16'd4: reset value of BAUDDIV, in clocks per bit.
- `clk`, in, 1: single clock. All state updates on its rising edge.
- `reset`, in, 1: asynchronous, active-low. While low, all state is held at its reset value.
- `daddr`, in, 32: byte address from the peripheral branch of the bus interface unit.
- `dwdata`, in, 32: write data.
- `dwe`, in, 4: per-byte write enables. All-zero means no write.
- `drdata`, out, 32: read data. Combinational from `daddr`; no wait states.
- `txd`, out, 1: serial output. Idle level is 1.

## Operation
- Register map, offsets from `BASE_ADDR`:
  - 0x0 TXDATA. Write with `dwe[0]`=1 pushes `dwdata[7:0]` into the FIFO. Reads return 0.
  - 0x4 STATUS. Read only, except bit 3. Fields:
    - bit0 busy: the state machine is not in IDLE.
    - bit1 full.
    - bit2 empty.
    - bit3 overflow: sticky. A write with `dwe[0]`=1 and `dwdata[3]`=1 clears it.
    - bits[8:4] count: current FIFO occupancy.
    - All other bits read 0.
  - 0x8 BAUDDIV. Bits[15:0] are writable per lane (`dwe[0]` writes [7:0], `dwe[1]` writes [15:8]). Bits[31:16] read 0.
  - 0xC: reads 0; writes are ignored.
- Writes take effect on the rising edge of `clk` on which `dwe` is nonzero.
- Register reads have no side effects.
- FIFO push:
  - A push is accepted if count < `FIFO_DEPTH`, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped and overflow is set.
  - On simultaneous push and pop, count is unchanged.
- Effective divisor: DIV = BAUDDIV, except that BAUDDIV = 0 is treated as 1.
- State machine, with a bit counter (0–7) and a down-counter:
  - IDLE: `txd`=1. If the FIFO is non-empty, pop the head into the shift register, load the counter with DIV−1, and go to START.
  - START: `txd`=0. When the counter reaches 0, reload it and go to DATA with bit counter 0.
  - DATA: `txd` = shift[0]. On counter 0, shift right and increment the bit counter. After bit 7, go to STOP.
  - STOP: `txd`=1. On counter 0:
    - if the FIFO is non-empty, pop and go directly to START (back-to-back frames, no idle gap);
    - otherwise go to IDLE.
- Data bits are sent LSB first.
- Each of the 10 frame bits lasts exactly DIV clocks, using the DIV value sampled at that bit's reload.
- A BAUDDIV write during a frame takes effect at the next bit boundary.

## Timing
- Reset values:
  - `txd`=1; state IDLE.
  - FIFO empty: count 0, pointers 0.
  - overflow 0; BAUDDIV = `DIV_RESET`.
  - `drdata` reflects these values; STATUS reads 0x4 after reset.
- Reset asserted mid-frame: `txd` goes to 1 asynchronously and FIFO contents are discarded. No partial frame resumes after release.
- Latency with an empty FIFO and IDLE:
  - TXDATA write at edge N gives count=1 after edge N.
  - Edge N+1 pops, so count returns to 0 and state is START.
  - `txd` falls after edge N+1.
- Frame length is 10×DIV clocks from the `txd` falling edge to the end of the stop bit.
- Busy deasserts on the edge that ends the stop bit when the FIFO is empty.
- FIFO pointers wrap modulo `FIFO_DEPTH`. Count is `$clog2(FIFO_DEPTH)+1` bits wide.
- `drdata` is valid in the same cycle as `daddr` and reflects register state as of the last edge.

## Test plan
- Reset with DIV=4, write 0xA5 to TXDATA → `txd` low 4 clocks starting one edge after the write. Data bits follow as 1,0,1,0,0,1,0,1 at 4 clocks each, then 4 clocks high. STATUS reads 0x4 after 40 clocks.
- Write 0x00 and 0xFF back-to-back → the second frame's start bit begins the clock immediately after the first frame's stop bit. Total 80 clocks with no idle gap.
- With BAUDDIV=100, write 10 bytes in 10 consecutive cycles → 9 accepted (1 popped immediately, 8 queued). STATUS reads full=1, overflow=1, count=8. Writing 0x8 to STATUS clears overflow. Exactly 9 frames are emitted.
- Set BAUDDIV=0, write 0x3C → each bit lasts 1 clock and the frame lasts 10 clocks.
- Assert reset during data bit 3 of a frame with 2 bytes queued → `txd`=1 immediately, STATUS reads 0x4 after release, and no further frames appear.
- Write BAUDDIV=2 during a DIV=4 start bit → the start bit lasts 4 clocks and every later bit lasts 2 clocks. Reading BAUDDIV returns 0x2.

Source files
------------

// File: rtl/uart_tx_periph.sv
// uart_tx_periph
//   Memory-mapped 8N1 UART transmitter with a small transmit FIFO.
//   Register map (offsets from BASE_ADDR, decoded on offset[3:2]):
//     0x0 TXDATA  (W)  dwe[0] pushes dwdata[7:0]; reads 0
//     0x4 STATUS  (R)  {count[8:4], overflow[3], empty[2], full[1], busy[0]}
//                      write dwe[0] with dwdata[3]=1 clears overflow
//     0x8 BAUDDIV (RW) clocks per bit in [15:0], byte-lane writable
//     0xC         reads 0, writes ignored
// Ports:
//   clk    : clock, all state updates on the rising edge
//   reset  : asynchronous active-low reset
//   daddr  : byte address from the peripheral bus branch
//   dwdata : write data
//   dwe    : per-byte write enables (all zero = no write)
//   drdata : combinational read data for daddr
//   txd    : serial output, idles high
module uart_tx_periph #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RESET  = 16'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] daddr,
    input  logic [31:0] dwdata,
    input  logic [3:0]  dwe,
    output logic [31:0] drdata,
    output logic        txd
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_e;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [31:0] off;
    logic [1:0]  sel;
    logic        wr_txdata;
    logic        wr_ovf_clr;
    logic        wr_div_lo;
    logic        wr_div_hi;

    assign off        = daddr - BASE_ADDR;
    assign sel        = off[3:2];
    assign wr_txdata  = (sel == 2'd0) && dwe[0];
    assign wr_ovf_clr = (sel == 2'd1) && dwe[0] && dwdata[3];
    assign wr_div_lo  = (sel == 2'd2) && dwe[0];
    assign wr_div_hi  = (sel == 2'd2) && dwe[1];

    logic unused_bits;
    assign unused_bits = &{1'b0, off[31:4], off[1:0], dwdata[31:16], dwe[3:2]};

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] rptr_q;
    logic [CW-1:0] count_q;
    logic          ovf_q;
    logic [15:0]   baud_q;

    state_e        state_q, state_d;
    logic [15:0]   cnt_q,   cnt_d;
    logic [2:0]    bit_q,   bit_d;
    logic [7:0]    shift_q, shift_d;

    logic          fifo_empty;
    logic          fifo_full;
    logic          pop;
    logic          push_ok;
    logic [15:0]   div_m1;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
    // A full FIFO still accepts a byte when the transmitter frees a slot
    // on the same edge.
    assign push_ok    = wr_txdata && (!fifo_full || pop);
    // BAUDDIV of zero behaves as one clock per bit.
    assign div_m1     = (baud_q == '0) ? '0 : baud_q - 16'd1;

    // ------------------------------------------------------------------
    // Transmit state machine: next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        txd     = 1'b1;
        unique case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rptr_q];
                    cnt_d   = div_m1;
                    state_d = S_START;
                end
            end
            S_START: begin
                txd = 1'b0;
                if (cnt_q == '0) begin
                    cnt_d   = div_m1;
                    bit_d   = '0;
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_DATA: begin
                txd = shift_q[0];
                if (cnt_q == '0) begin
                    cnt_d   = div_m1;
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_STOP: begin
                if (cnt_q == '0) begin
                    // Chain straight into the next start bit when data is waiting.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rptr_q];
                        cnt_d   = div_m1;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    // ------------------------------------------------------------------
    // FIFO, overflow flag and divisor register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            baud_q  <= DIV_RESET;
        end else begin
            if (push_ok) begin
                mem_q[wptr_q] <= dwdata[7:0];
                wptr_q        <= wptr_q + AW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + AW'(1);
            end
            unique case ({push_ok, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase

            if (wr_txdata && !push_ok) begin
                ovf_q <= 1'b1;
            end else if (wr_ovf_clr) begin
                ovf_q <= 1'b0;
            end

            if (wr_div_lo) begin
                baud_q[7:0] <= dwdata[7:0];
            end
            if (wr_div_hi) begin
                baud_q[15:8] <= dwdata[15:8];
            end
        end
    end

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    logic [31:0] status;
    assign status = {23'd0, 5'(count_q), ovf_q, fifo_empty, fifo_full,
                     (state_q != S_IDLE)};

    always_comb begin
        drdata = '0;
        unique case (sel)
            2'd1:    drdata = status;
            2'd2:    drdata = {16'd0, baud_q};
            default: drdata = '0;
        endcase
    end

endmodule
